// File: rtl/lfsr_rx.sv
// LFSR reference receiver: assembles LSB-first serial frames and compares each one with a local Fibonacci LFSR.
// Define LFSR_RX_ERRCNT_EN to build the saturating mismatch counter; otherwise Err_Count is tied to 0.
module lfsr_rx #(
  parameter int LFSR_WD = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [LFSR_WD-1:0] Seed,
  input  logic               Seed_Load,
  input  logic               Enable,
  input  logic               Serial_In,
  input  logic               Serial_Valid,
  output logic [LFSR_WD-1:0] Data,
  output logic               Data_Valid,
  output logic               Match,
  output logic               Frame_Error,
  output logic [7:0]         Err_Count
);

  localparam int CNT_WD = (LFSR_WD > 2) ? $clog2(LFSR_WD) : 1;
  localparam logic [CNT_WD-1:0] LAST_BIT = CNT_WD'(LFSR_WD - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         rst_sync;
  logic               rst_n;
  logic [1:0]         state;
  logic [CNT_WD-1:0]  bit_cnt;
  logic [LFSR_WD-2:0] shift_reg;
  logic [LFSR_WD-1:0] lfsr;
  logic [LFSR_WD-1:0] frame_word;
  logic               lfsr_fb;

  // Reset asserts at once but releases two edges later, so the FSM never starts on a marginal edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n      = rst_sync[1];
  assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign frame_word = {Serial_In, shift_reg};

  // The reference only moves between frames; an all-zero seed would lock the LFSR up.
  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= '0;
    end else if (state == IDLE) begin
      if (Seed_Load)   lfsr <= (Seed == '0) ? LFSR_WD'(1) : Seed;
      else if (Enable) lfsr <= {lfsr[LFSR_WD-2:0], lfsr_fb};
    end
  end

  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      Data        <= '0;
      Data_Valid  <= 1'b0;
      Match       <= 1'b0;
      Frame_Error <= 1'b0;
    end else begin
      Data_Valid  <= 1'b0;
      Frame_Error <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (Serial_Valid) begin
            shift_reg <= {Serial_In, shift_reg[LFSR_WD-2:1]};
            bit_cnt   <= CNT_WD'(1);
            state     <= RECV;
          end
        end
        RECV: begin
          if (!Serial_Valid) begin
            Frame_Error <= 1'b1;
            bit_cnt     <= '0;
            state       <= IDLE;
          end else if (bit_cnt == LAST_BIT) begin
            Data       <= frame_word;
            Match      <= (frame_word == lfsr);
            Data_Valid <= 1'b1;
            bit_cnt    <= '0;
            state      <= DONE;
          end else begin
            shift_reg <= {Serial_In, shift_reg[LFSR_WD-2:1]};
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end
        default: begin
          bit_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef LFSR_RX_ERRCNT_EN
  logic [7:0] err_cnt;

  // Counts frames that completed with a mismatch, sticking at all-ones.
  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'h00;
    end else if ((state == DONE) && !Match && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end

  assign Err_Count = err_cnt;
`else
  assign Err_Count = 8'h00;
`endif

endmodule
